ohm_meter: RTL and testbench

Multi-channel, parametrised successor to the single-channel igniter resistance divider. It accepts ADC voltage/current sample pairs tagged with a channel number and computes R = V·SCALE / I >> FRAC with one shared radix-4 restoring divider (2 quotient bits per cycle). For each channel it holds the latest resistance, open-circuit, saturation and continuity results. It sits between the launch-controller ADC sequencer and the display and arming logic.

---
 rtl/ohm_meter_pkg.sv | 40 ++++
 rtl/ohm_radix4_div.sv | 94 +++++++++
 rtl/ohm_meter.sv | 150 +++++++++++++++
 tb/tb_ohm_meter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ohm_meter_pkg.sv
//============================================================================
// ohm_meter_pkg: shared FSM states, width helpers and ADC code decode.
// Rev 1.0
//============================================================================
`default_nettype none

package ohm_meter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int unsigned num_w(input int unsigned m_w);
    return m_w + 16;
  endfunction

  function automatic int unsigned steps(input int unsigned nw);
    return (nw + 1) / 2;
  endfunction

  function automatic int unsigned ch_w(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // ADC codes are offset-inverted: MSB set is negative, else magnitude = ~code.
  function automatic logic adc_neg(input logic [31:0] code, input int unsigned adc_w);
    return ((code >> (adc_w - 1)) & 32'd1) != 32'd0;
  endfunction

  function automatic logic [31:0] adc_mag(input logic [31:0] code, input int unsigned adc_w);
    logic [31:0] mask;
    mask = (32'd1 << (adc_w - 1)) - 32'd1;
    return (~code) & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ohm_radix4_div.sv
//============================================================================
// ohm_radix4_div: radix-4 restoring divider, 2 quotient bits per cycle.
// Rev 1.0
//============================================================================
`default_nettype none

module ohm_radix4_div
  import ohm_meter_pkg::*;
#(
  parameter int unsigned NUM_W = 27,
  parameter int unsigned DEN_W = 11,
  localparam int unsigned Q_W   = 2 * steps(NUM_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [DEN_W-1:0] den_i,
  output logic             done_o,
  output logic [Q_W-1:0]   quot_o
);

  localparam int unsigned STEPS = steps(NUM_W);
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned RQ_W  = DEN_W + 1;
  localparam int unsigned REM_W = DEN_W + 3;

  logic             run_q;
  logic [CNT_W-1:0] cnt_q;
  logic [Q_W-1:0]   sh_q;
  logic [Q_W-1:0]   quot_q;
  logic [RQ_W-1:0]  rem_q;
  logic [REM_W-1:0] d1_q, d2_q, d3_q;

  logic [REM_W-1:0] w_part;
  logic [REM_W:0]   w_diff1, w_diff2, w_diff3;
  logic [REM_W-1:0] w_rem_sel;
  logic [1:0]       w_digit;

  assign w_part  = {rem_q, sh_q[Q_W-1 -: 2]};
  assign w_diff1 = {1'b0, w_part} - {1'b0, d1_q};
  assign w_diff2 = {1'b0, w_part} - {1'b0, d2_q};
  assign w_diff3 = {1'b0, w_part} - {1'b0, d3_q};

  // Largest multiple that leaves a non-negative remainder wins.
  always_comb begin
    w_digit   = 2'd0;
    w_rem_sel = w_part;
    if (!w_diff3[REM_W]) begin
      w_digit   = 2'd3;
      w_rem_sel = w_diff3[REM_W-1:0];
    end else if (!w_diff2[REM_W]) begin
      w_digit   = 2'd2;
      w_rem_sel = w_diff2[REM_W-1:0];
    end else if (!w_diff1[REM_W]) begin
      w_digit   = 2'd1;
      w_rem_sel = w_diff1[REM_W-1:0];
    end
  end

  assign done_o = run_q && (cnt_q == CNT_W'(STEPS - 1));
  assign quot_o = (quot_q << 2) | Q_W'(w_digit);

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      sh_q   <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      d1_q   <= '0;
      d2_q   <= '0;
      d3_q   <= '0;
    end else if (start_i) begin
      run_q  <= 1'b1;
      cnt_q  <= '0;
      sh_q   <= Q_W'(num_i);
      quot_q <= '0;
      rem_q  <= '0;
      d1_q   <= REM_W'(den_i);
      d2_q   <= REM_W'(den_i) << 1;
      d3_q   <= REM_W'(den_i) + (REM_W'(den_i) << 1);
    end else if (run_q) begin
      cnt_q  <= cnt_q + 1'b1;
      sh_q   <= sh_q << 2;
      quot_q <= quot_o;
      rem_q  <= RQ_W'(w_rem_sel);
      if (done_o) run_q <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ohm_meter.sv
//============================================================================
// ohm_meter: multi-channel igniter resistance meter, R = V*SCALE/I >> FRAC.
// Rev 1.0
//============================================================================
`default_nettype none

module ohm_meter
  import ohm_meter_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned ADC_W   = 12,
  parameter int unsigned SCALE   = 42089,
  parameter int unsigned FRAC    = 10,
  parameter int unsigned R_W     = 12,
  parameter int unsigned I_MIN   = 1,
  parameter int unsigned R_LO    = 1,
  parameter int unsigned R_HI    = 10,
  parameter bit          OUT_INV = 1'b0,
  localparam int unsigned CH_W   = ch_w(NCH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  output logic               ready_in,
  input  logic [CH_W-1:0]    ch_in,
  input  logic [ADC_W-1:0]   v_in,
  input  logic [ADC_W-1:0]   i_in,
  output logic               valid_out,
  output logic [CH_W-1:0]    ch_out,
  output logic [R_W-1:0]     r_out,
  output logic               open_out,
  output logic               sat_out,
  output logic [NCH*R_W-1:0] r_hold,
  output logic [NCH-1:0]     cont_ok
);

  localparam int unsigned   M_W     = ADC_W - 1;
  localparam int unsigned   NUM_W   = num_w(M_W);
  localparam int unsigned   Q_W     = 2 * steps(NUM_W);
  localparam logic [15:0]   SCALE_C = SCALE[15:0];
  localparam logic [Q_W-1:0] R_MAX_C = Q_W'((64'd1 << R_W) - 64'd1);

  state_t state_q, state_d;
  logic [CH_W-1:0] ch_q;
  logic            open_q;
  logic            valid_q, open_out_q, sat_out_q;
  logic [CH_W-1:0] ch_out_q;
  logic [R_W-1:0]  r_out_q;
  logic [NCH*R_W-1:0] r_hold_q;
  logic [NCH-1:0]     cont_q;

  logic             w_v_neg, w_i_neg, w_open, w_accept, w_fin, w_div_done;
  logic [M_W-1:0]   w_v_mag, w_i_mag, w_den;
  logic [NUM_W-1:0] w_num;
  logic [Q_W-1:0]   w_quot, w_qs;
  logic             w_sat, w_cont;
  logic [R_W-1:0]   w_r, w_r_disp;

  assign w_v_neg = adc_neg(32'(v_in), ADC_W);
  assign w_i_neg = adc_neg(32'(i_in), ADC_W);
  assign w_v_mag = w_v_neg ? '0 : M_W'(adc_mag(32'(v_in), ADC_W));
  assign w_i_mag = M_W'(adc_mag(32'(i_in), ADC_W));
  assign w_open  = w_i_neg || (32'(w_i_mag) < I_MIN);
  // Open circuit still runs the full division so the timing never changes.
  assign w_den   = w_open ? M_W'(1) : w_i_mag;
  assign w_num   = {16'd0, w_v_mag} * {{M_W{1'b0}}, SCALE_C};

  assign w_accept = valid_in && (state_q == S_IDLE);
  assign w_fin    = (state_q == S_CALC) && w_div_done;

  ohm_radix4_div #(
    .NUM_W (NUM_W),
    .DEN_W (M_W)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .start_i (w_accept),
    .num_i   (w_num),
    .den_i   (w_den),
    .done_o  (w_div_done),
    .quot_o  (w_quot)
  );

  assign w_qs     = w_quot >> FRAC;
  assign w_sat    = !open_q && (w_qs > R_MAX_C);
  assign w_r      = (open_q || w_sat) ? '1 : w_qs[R_W-1:0];
  assign w_cont   = !open_q && !w_sat && (32'(w_r) >= R_LO) && (32'(w_r) <= R_HI);
  assign w_r_disp = OUT_INV ? {1'b0, ~w_r[R_W-2:0]} : w_r;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_accept) state_d = S_CALC;
      S_CALC:  if (w_div_done) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      open_q     <= 1'b0;
      valid_q    <= 1'b0;
      ch_out_q   <= '0;
      r_out_q    <= '0;
      open_out_q <= 1'b0;
      sat_out_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= w_fin;
      if (w_accept) begin
        ch_q   <= ch_in;
        open_q <= w_open;
      end
      if (w_fin) begin
        ch_out_q   <= ch_q;
        r_out_q    <= w_r_disp;
        open_out_q <= open_q;
        sat_out_q  <= w_sat;
      end
    end
  end

  // An out-of-range channel tag matches no slot, so no hold register moves.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    always_ff @(posedge clk) begin
      if (reset) begin
        r_hold_q[k*R_W +: R_W] <= '0;
        cont_q[k]              <= 1'b0;
      end else if (w_fin && (ch_q == CH_W'(k))) begin
        r_hold_q[k*R_W +: R_W] <= w_r_disp;
        cont_q[k]              <= w_cont;
      end
    end
  end

  assign ready_in  = (state_q == S_IDLE);
  assign valid_out = valid_q;
  assign ch_out    = ch_out_q;
  assign r_out     = r_out_q;
  assign open_out  = open_out_q;
  assign sat_out   = sat_out_q;
  assign r_hold    = r_hold_q;
  assign cont_ok   = cont_q;

endmodule

`default_nettype wire

// File: tb/tb_ohm_meter.sv
//============================================================================
// tb_ohm_meter: randomized scoreboard bench for ohm_meter (default params).
// Rev 1.0
//============================================================================
`default_nettype none

module tb_ohm_meter;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        ready_in;
  logic [1:0]  ch_in;
  logic [11:0] v_in, i_in;
  logic        valid_out;
  logic [1:0]  ch_out;
  logic [11:0] r_out;
  logic        open_out, sat_out;
  logic [47:0] r_hold;
  logic [3:0]  cont_ok;

  ohm_meter dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .ch_in     (ch_in),
    .v_in      (v_in),
    .i_in      (i_in),
    .valid_out (valid_out),
    .ch_out    (ch_out),
    .r_out     (r_out),
    .open_out  (open_out),
    .sat_out   (sat_out),
    .r_hold    (r_hold),
    .cont_ok   (cont_ok)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ch;
    int r;
    bit op;
    bit sat;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   mdl_r[4];
  bit   mdl_c[4];
  int   errors = 0;
  int   checks = 0;
  bit   burst = 0;
  int   last_acc = -1;
  int   burst_n = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: decode to signed-magnitude integers, then plain integer division.
  function automatic exp_t model(input int ch, input int v, input int i, input int c);
    exp_t e;
    int vv, ii, q;
    bit neg;
    vv  = (v >= 2048) ? 0 : 2047 - v;
    neg = (i >= 2048);
    ii  = neg ? 0 : 2047 - i;
    e.ch  = ch;
    e.acc = c;
    e.op  = neg || (ii < 1);
    if (e.op) begin
      e.r   = 4095;
      e.sat = 1'b0;
    end else begin
      q     = (vv * 42089) / ii / 1024;
      e.sat = (q > 4095);
      e.r   = e.sat ? 4095 : q;
    end
    return e;
  endfunction

  // Accept observer: records expected response for every handshake.
  always @(negedge clk) begin
    if (!reset && valid_in && ready_in) begin
      sb.push_back(model(int'(ch_in), int'(v_in), int'(i_in), cyc));
      if (burst) begin
        if (last_acc >= 0) chk("accept_gap", cyc - last_acc, 16);
        last_acc = cyc;
        burst_n++;
      end
    end
  end

  exp_t me;
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      for (int k = 0; k < 4; k++) begin
        mdl_r[k] = 0;
        mdl_c[k] = 1'b0;
      end
    end else if (valid_out) begin
      if (sb.size() == 0) begin
        chk("spurious_strobe", 1, 0);
      end else begin
        me = sb.pop_front();
        chk("latency", cyc - me.acc, 15);
        chk("ch_out", int'(ch_out), me.ch);
        chk("r_out", int'(r_out), me.r);
        chk("open_out", int'(open_out), int'(me.op));
        chk("sat_out", int'(sat_out), int'(me.sat));
        mdl_r[me.ch] = me.r;
        mdl_c[me.ch] = !me.op && !me.sat && (me.r >= 1) && (me.r <= 10);
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("r_hold[%0d]", k), int'(r_hold[k*12 +: 12]), mdl_r[k]);
          chk($sformatf("cont_ok[%0d]", k), int'(cont_ok[k]), int'(mdl_c[k]));
        end
      end
    end
  end

  task automatic send(input int ch, input int v, input int i, input bit keep);
    int n;
    ch_in    = 2'(ch);
    v_in     = 12'(v);
    i_in     = 12'(i);
    valid_in = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ready_in && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_in) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep) valid_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", sb.size(), 0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ready"}, int'(ready_in), 1);
    chk({tag, "_valid"}, int'(valid_out), 0);
    chk({tag, "_ch"}, int'(ch_out), 0);
    chk({tag, "_r"}, int'(r_out), 0);
    chk({tag, "_open"}, int'(open_out), 0);
    chk({tag, "_sat"}, int'(sat_out), 0);
    chk({tag, "_rhold_nz"}, int'(r_hold != 48'd0), 0);
    chk({tag, "_cont"}, int'(cont_ok), 0);
  endtask

  initial begin
    int mode, iv, g;
    bit keep;
    reset = 1'b1; valid_in = 1'b0; ch_in = '0; v_in = '0; i_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_values("rst0");
    @(posedge clk);
    #1;

    send(0, 'h79B, 'h737, 0); drain();
    chk("tp1_r", int'(r_out), 20);
    chk("tp1_cont0", int'(cont_ok[0]), 0);
    send(1, 'h79B, 'h417, 0); drain();
    chk("tp2_r", int'(r_out), 4);
    chk("tp2_cont1", int'(cont_ok[1]), 1);
    chk("tp2_hold0", int'(r_hold[11:0]), 20);
    send(2, 'h79B, 'h800, 0); drain();
    chk("open_neg", int'(open_out), 1);
    chk("open_neg_r", int'(r_out), 4095);
    send(3, 'h79B, 'h7FF, 0); drain();
    chk("open_zero", int'(open_out), 1);
    chk("open_zero_sat", int'(sat_out), 0);
    chk("open_zero_cont", int'(cont_ok[3]), 0);
    send(2, 'h000, 'h7FE, 0); drain();
    chk("sat_flag", int'(sat_out), 1);
    chk("sat_r", int'(r_out), 4095);
    send(2, 'h800, 'h7FE, 0); drain();
    chk("vneg_r", int'(r_out), 0);

    burst = 1'b1; last_acc = -1; burst_n = 0;
    for (int c = 0; c < 4; c++)
      send(c, $urandom_range(0, 4095), 2047 - $urandom_range(1, 2047), c != 3);
    drain();
    burst = 1'b0;
    chk("burst_accepts", burst_n, 4);

    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0:       iv = $urandom_range(0, 4095);
        1:       iv = 2047 - $urandom_range(1, 20);
        2:       iv = $urandom_range(0, 1) ? 'h7FF : $urandom_range(2048, 4095);
        default: iv = 2047 - $urandom_range(400, 2047);
      endcase
      keep = (n != 39) && ($urandom_range(0, 1) == 1);
      send($urandom_range(0, 3), $urandom_range(0, 4095), iv, keep);
      if (!keep) begin
        g = $urandom_range(0, 3);
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
    end
    drain();

    send(0, 'h79B, 'h737, 0);
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    send_after_reset: begin
      ch_in = 2'd2; v_in = 12'h79B; i_in = 12'h417; valid_in = 1'b1;
      @(negedge clk);
      chk_reset_values("rst_mid");
      @(posedge clk);
      #1 valid_in = 1'b0;
    end
    drain();
    chk("post_rst_r", int'(r_out), 4);
    chk("post_rst_hold0", int'(r_hold[11:0]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
